sc_fifo_ram: RTL and testbench

//  Single-clock FIFO built on an inferred 2**C_ADR_W x C_DAT_W RAM with

---
 rtl/sc_fifo_ram.sv | 191 +++++++++++++++++++
 tb/tb_sc_fifo_ram.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_ram.sv
// sc_fifo_ram: single-clock FIFO built on an inferred 2**C_ADR_W x C_DAT_W RAM.
// The read data is registered. The FIFO tracks an occupancy count and drives
// full/empty and almost-full/almost-empty flags. Overflow and underflow errors
// are sticky. A synchronous clear flushes the FIFO.
// All flags come from the next-state count, so they change on the same edge
// as CNTs_o.

module sc_fifo_ram #(
   parameter int C_DAT_W  = 8,
   parameter int C_ADR_W  = 10,
   parameter int C_AF_LVL = 1020,
   parameter int C_AE_LVL = 4
) (
   input  logic               CK_i,
   input  logic               XAR_i,
   input  logic               CLR_i,
   input  logic               WE_i,
   input  logic [C_DAT_W-1:0] WDs_i,
   input  logic               RE_i,
   output logic [C_DAT_W-1:0] RDs_o,
   output logic               RDV_o,
   output logic               FULL_o,
   output logic               EMPTY_o,
   output logic               AFULL_o,
   output logic               AEMPTY_o,
   output logic [C_ADR_W:0]   CNTs_o,
   output logic               OVF_o,
   output logic               UDF_o
);

   localparam int                 CW       = C_ADR_W + 1;
   localparam int                 DEPTH    = 2 ** C_ADR_W;
   localparam logic [CW-1:0]      CNT_MAX  = CW'(DEPTH);
   localparam logic [CW-1:0]      CNT_ZERO = CW'(1'b0);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0]      AF_LVL   = CW'(C_AF_LVL);
   localparam logic [CW-1:0]      AE_LVL   = CW'(C_AE_LVL);
   localparam logic [C_ADR_W-1:0] PTR_ZERO = C_ADR_W'(1'b0);
   localparam logic [C_ADR_W-1:0] PTR_ONE  = C_ADR_W'(1'b1);
   localparam logic [C_DAT_W-1:0] DAT_ZERO = C_DAT_W'(1'b0);

   // flag vector layout: {full, empty, afull, aempty}
   function automatic logic [3:0] flags_f(input logic [CW-1:0] cnt);
      logic [3:0] f;
      f[3] = (cnt == CNT_MAX);
      f[2] = (cnt == CNT_ZERO);
      f[1] = (cnt >= AF_LVL);
      f[0] = (cnt <= AE_LVL);
      return f;
   endfunction

   // pointers wrap naturally modulo the RAM depth
   function automatic logic [C_ADR_W-1:0] ptr_inc_f(input logic [C_ADR_W-1:0] p);
      return p + PTR_ONE;
   endfunction

   logic [C_DAT_W-1:0] mem_r [DEPTH];
   logic [C_ADR_W-1:0] wa_r;
   logic [C_ADR_W-1:0] ra_r;
   logic [CW-1:0]      cnt_r;
   logic [C_DAT_W-1:0] rd_data_r;
   logic               rd_valid_r;
   logic               full_r;
   logic               empty_r;
   logic               afull_r;
   logic               aempty_r;
   logic               ovf_r;
   logic               udf_r;

   logic               wr_ok_s;
   logic               rd_ok_s;
   logic [CW-1:0]      cnt_nxt_s;
   logic [3:0]         flags_nxt_s;
   logic [3:0]         flags_rst_s;

   // accept decisions use the flags registered at this edge; clear blocks both
   always_comb begin
      wr_ok_s = 1'b0;
      rd_ok_s = 1'b0;
      if (CLR_i) begin
         wr_ok_s = 1'b0;
         rd_ok_s = 1'b0;
      end else begin
         wr_ok_s = WE_i & ~full_r;
         rd_ok_s = RE_i & ~empty_r;
      end
   end

   // next occupancy: +1 write only, -1 read only, hold otherwise, 0 on clear
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (CLR_i) begin
         cnt_nxt_s = CNT_ZERO;
      end else begin
         case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
            2'b11:   cnt_nxt_s = cnt_r;
            default: cnt_nxt_s = cnt_r;
         endcase
      end
   end

   // flags for the next count and for the reset state (count 0)
   always_comb begin
      flags_nxt_s = flags_f(cnt_nxt_s);
      flags_rst_s = flags_f(CNT_ZERO);
   end

   // RAM write port; contents are not reset
   always_ff @(posedge CK_i) begin
      if (wr_ok_s) begin
         mem_r[wa_r] <= WDs_i;
      end
   end

   // pointers and occupancy
   always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i) begin
         wa_r  <= PTR_ZERO;
         ra_r  <= PTR_ZERO;
         cnt_r <= CNT_ZERO;
      end else if (CLR_i) begin
         wa_r  <= PTR_ZERO;
         ra_r  <= PTR_ZERO;
         cnt_r <= CNT_ZERO;
      end else begin
         if (wr_ok_s) begin
            wa_r <= ptr_inc_f(wa_r);
         end
         if (rd_ok_s) begin
            ra_r <= ptr_inc_f(ra_r);
         end
         cnt_r <= cnt_nxt_s;
      end
   end

   // registered read data and valid strobe; data holds when no read is accepted
   always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i) begin
         rd_data_r  <= DAT_ZERO;
         rd_valid_r <= 1'b0;
      end else if (CLR_i) begin
         rd_data_r  <= DAT_ZERO;
         rd_valid_r <= 1'b0;
      end else begin
         if (rd_ok_s) begin
            rd_data_r <= mem_r[ra_r];
         end
         rd_valid_r <= rd_ok_s;
      end
   end

   // status flags registered from the next count
   always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i) begin
         {full_r, empty_r, afull_r, aempty_r} <= flags_rst_s;
      end else begin
         {full_r, empty_r, afull_r, aempty_r} <= flags_nxt_s;
      end
   end

   // sticky error flags; clear wins over any concurrent request
   always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else if (CLR_i) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         if (WE_i && full_r) begin
            ovf_r <= 1'b1;
         end
         if (RE_i && empty_r) begin
            udf_r <= 1'b1;
         end
      end
   end

   assign RDs_o    = rd_data_r;
   assign RDV_o    = rd_valid_r;
   assign FULL_o   = full_r;
   assign EMPTY_o  = empty_r;
   assign AFULL_o  = afull_r;
   assign AEMPTY_o = aempty_r;
   assign CNTs_o   = cnt_r;
   assign OVF_o    = ovf_r;
   assign UDF_o    = udf_r;

endmodule

// File: tb/tb_sc_fifo_ram.sv
// Directed testbench for sc_fifo_ram (depth 4, AF at 3, AE at 1).
// Flag vectors are compared as {FULL, EMPTY, AFULL, AEMPTY, OVF, UDF}.

module tb_sc_fifo_ram;

   logic       CK_i = 1'b0;
   logic       XAR_i = 1'b0;
   logic       CLR_i = 1'b0;
   logic       WE_i = 1'b0;
   logic [7:0] WDs_i = 8'h00;
   logic       RE_i = 1'b0;
   logic [7:0] RDs_o;
   logic       RDV_o;
   logic       FULL_o;
   logic       EMPTY_o;
   logic       AFULL_o;
   logic       AEMPTY_o;
   logic [2:0] CNTs_o;
   logic       OVF_o;
   logic       UDF_o;

   int total = 0;
   int bad   = 0;

   sc_fifo_ram #(
      .C_DAT_W (8),
      .C_ADR_W (2),
      .C_AF_LVL(3),
      .C_AE_LVL(1)
   ) dut (
      .CK_i    (CK_i),
      .XAR_i   (XAR_i),
      .CLR_i   (CLR_i),
      .WE_i    (WE_i),
      .WDs_i   (WDs_i),
      .RE_i    (RE_i),
      .RDs_o   (RDs_o),
      .RDV_o   (RDV_o),
      .FULL_o  (FULL_o),
      .EMPTY_o (EMPTY_o),
      .AFULL_o (AFULL_o),
      .AEMPTY_o(AEMPTY_o),
      .CNTs_o  (CNTs_o),
      .OVF_o   (OVF_o),
      .UDF_o   (UDF_o)
   );

   always #5 CK_i = ~CK_i;

   // advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge CK_i);
      #1;
   endtask

   task automatic test_reset();
      XAR_i = 1'b0;
      #12;
      XAR_i = 1'b1;
      step();
      step();
      total++;
      if ({FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o} !== 6'b010100) begin
         bad++;
         $display("FAIL reset_flags got=%b want=%b", {FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o}, 6'b010100);
      end
      total++;
      if ({CNTs_o, RDV_o, RDs_o} !== {3'd0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset_data got cnt=%0d rdv=%b rd=%h want cnt=0 rdv=0 rd=00", CNTs_o, RDV_o, RDs_o);
      end
   endtask

   task automatic test_fill();
      logic [7:0] d;
      logic [5:0] f;
      for (int i = 0; i < 4; i++) begin
         d = 8'(8'h11 * (i + 1));
         WE_i = 1'b1; WDs_i = d;
         step();
         f = {(i == 3), 1'b0, (i >= 2), (i == 0), 1'b0, 1'b0};
         total++;
         if (CNTs_o !== 3'(i + 1)) begin
            bad++;
            $display("FAIL fill_cnt[%0d] got=%0d want=%0d", i, CNTs_o, i + 1);
         end
         total++;
         if ({FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o} !== f) begin
            bad++;
            $display("FAIL fill_flags[%0d] got=%b want=%b", i, {FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o}, f);
         end
      end
      WDs_i = 8'h55;
      step();
      WE_i = 1'b0;
      total++;
      if ({CNTs_o, FULL_o, OVF_o} !== {3'd4, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL overflow got cnt=%0d full=%b ovf=%b want cnt=4 full=1 ovf=1", CNTs_o, FULL_o, OVF_o);
      end
   endtask

   task automatic test_drain();
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 8'(8'h11 * (i + 1));
         RE_i = 1'b1;
         step();
         total++;
         if ({RDV_o, RDs_o, CNTs_o} !== {1'b1, d, 3'(3 - i)}) begin
            bad++;
            $display("FAIL drain[%0d] got rdv=%b rd=%h cnt=%0d want rdv=1 rd=%h cnt=%0d", i, RDV_o, RDs_o, CNTs_o, d, 3 - i);
         end
      end
      step();
      RE_i = 1'b0;
      total++;
      if ({UDF_o, RDV_o, RDs_o, EMPTY_o, AEMPTY_o, CNTs_o} !== {1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 3'd0}) begin
         bad++;
         $display("FAIL underflow got udf=%b rdv=%b rd=%h empty=%b aempty=%b cnt=%0d want 1 0 44 1 1 0", UDF_o, RDV_o, RDs_o, EMPTY_o, AEMPTY_o, CNTs_o);
      end
      total++;
      if (OVF_o !== 1'b1) begin
         bad++;
         $display("FAIL ovf_sticky got=%b want=1", OVF_o);
      end
      CLR_i = 1'b1;
      step();
      CLR_i = 1'b0;
      total++;
      if ({OVF_o, UDF_o, RDs_o, CNTs_o} !== {1'b0, 1'b0, 8'h00, 3'd0}) begin
         bad++;
         $display("FAIL clear_errors got ovf=%b udf=%b rd=%h cnt=%0d want 0 0 00 0", OVF_o, UDF_o, RDs_o, CNTs_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [$];
      logic [7:0] e;
      WE_i = 1'b1;
      WDs_i = 8'hA0; step();
      WDs_i = 8'hA1; step();
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'hA1);
      RE_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         WDs_i = 8'(i);
         step();
         exp_q.push_back(8'(i));
         e = exp_q.pop_front();
         total++;
         if ({RDV_o, RDs_o, CNTs_o} !== {1'b1, e, 3'd2}) begin
            bad++;
            $display("FAIL stream[%0d] got rdv=%b rd=%h cnt=%0d want rdv=1 rd=%h cnt=2", i, RDV_o, RDs_o, CNTs_o, e);
         end
      end
      WE_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({RDV_o, RDs_o, CNTs_o} !== {1'b1, e, 3'(1 - i)}) begin
            bad++;
            $display("FAIL stream_tail[%0d] got rdv=%b rd=%h cnt=%0d want rdv=1 rd=%h cnt=%0d", i, RDV_o, RDs_o, CNTs_o, e, 1 - i);
         end
      end
      RE_i = 1'b0;
      step();
      total++;
      if ({EMPTY_o, RDV_o, UDF_o, OVF_o} !== 4'b1000) begin
         bad++;
         $display("FAIL stream_end got empty=%b rdv=%b udf=%b ovf=%b want 1 0 0 0", EMPTY_o, RDV_o, UDF_o, OVF_o);
      end
   endtask

   task automatic test_simultaneous();
      WE_i = 1'b1; RE_i = 1'b1; WDs_i = 8'h66;
      step();
      RE_i = 1'b0;
      total++;
      if ({CNTs_o, UDF_o, RDV_o, EMPTY_o} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL simul_empty got cnt=%0d udf=%b rdv=%b empty=%b want cnt=1 udf=1 rdv=0 empty=0", CNTs_o, UDF_o, RDV_o, EMPTY_o);
      end
      WDs_i = 8'h77; step();
      WDs_i = 8'h88; step();
      WDs_i = 8'h99; step();
      total++;
      if ({CNTs_o, FULL_o, OVF_o} !== {3'd4, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL simul_fill got cnt=%0d full=%b ovf=%b want cnt=4 full=1 ovf=0", CNTs_o, FULL_o, OVF_o);
      end
      RE_i = 1'b1; WDs_i = 8'hAA;
      step();
      WE_i = 1'b0; RE_i = 1'b0;
      total++;
      if ({CNTs_o, OVF_o, RDV_o, RDs_o, FULL_o, AFULL_o} !== {3'd3, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL simul_full got cnt=%0d ovf=%b rdv=%b rd=%h full=%b afull=%b want 3 1 1 66 0 1", CNTs_o, OVF_o, RDV_o, RDs_o, FULL_o, AFULL_o);
      end
   endtask

   task automatic test_clear();
      CLR_i = 1'b1; WE_i = 1'b1; RE_i = 1'b1; WDs_i = 8'hEE;
      step();
      CLR_i = 1'b0; WE_i = 1'b0; RE_i = 1'b0;
      total++;
      if ({CNTs_o, RDV_o, RDs_o} !== {3'd0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL clear_data got cnt=%0d rdv=%b rd=%h want cnt=0 rdv=0 rd=00", CNTs_o, RDV_o, RDs_o);
      end
      total++;
      if ({FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o} !== 6'b010100) begin
         bad++;
         $display("FAIL clear_flags got=%b want=%b", {FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o}, 6'b010100);
      end
   endtask

   task automatic test_async_reset();
      WE_i = 1'b1;
      WDs_i = 8'h12; step();
      WDs_i = 8'h34; step();
      WE_i = 1'b0; RE_i = 1'b1;
      step();
      RE_i = 1'b0;
      total++;
      if ({RDV_o, RDs_o, CNTs_o} !== {1'b1, 8'h12, 3'd1}) begin
         bad++;
         $display("FAIL pre_reset got rdv=%b rd=%h cnt=%0d want rdv=1 rd=12 cnt=1", RDV_o, RDs_o, CNTs_o);
      end
      #2;
      XAR_i = 1'b0;
      #1;
      total++;
      if ({CNTs_o, RDV_o, RDs_o} !== {3'd0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL async_reset_data got cnt=%0d rdv=%b rd=%h want cnt=0 rdv=0 rd=00", CNTs_o, RDV_o, RDs_o);
      end
      total++;
      if ({FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o} !== 6'b010100) begin
         bad++;
         $display("FAIL async_reset_flags got=%b want=%b", {FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, OVF_o, UDF_o}, 6'b010100);
      end
      #3;
      XAR_i = 1'b1;
      WE_i = 1'b1; WDs_i = 8'h5A;
      step();
      WE_i = 1'b0; RE_i = 1'b1;
      step();
      RE_i = 1'b0;
      total++;
      if ({RDV_o, RDs_o, CNTs_o} !== {1'b1, 8'h5A, 3'd0}) begin
         bad++;
         $display("FAIL post_reset got rdv=%b rd=%h cnt=%0d want rdv=1 rd=5a cnt=0", RDV_o, RDs_o, CNTs_o);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_simultaneous();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
